// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM encoding, master indices and
// default timeout/error-data values.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } arb_state_e;

  localparam int unsigned MASTER_CORE = 0;
  localparam int unsigned MASTER_DMA  = 1;

  localparam int unsigned DEFAULT_TIMEOUT  = 255;
  localparam logic [15:0] DEFAULT_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/mem_arbiter_req.sv
// Per-master front end: accepts a request while ready, holds it until the arbiter completes it,
// and returns the response data with a one-cycle data_ready pulse.
module mem_arbiter_req #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  exec_i,
  input  logic                  write_i,
  input  logic [1:0]            size_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] data_out_i,
  input  logic                  complete_i,
  input  logic [DATA_WIDTH-1:0] rsp_data_i,
  output logic                  ready_o,
  output logic                  data_ready_o,
  output logic [DATA_WIDTH-1:0] data_in_o,
  output logic                  pending_o,
  output logic                  req_write_o,
  output logic [1:0]            req_size_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [DATA_WIDTH-1:0] req_data_o
);

  logic                  pending_d, pending_q;
  logic                  data_ready_d, data_ready_q;
  logic [DATA_WIDTH-1:0] data_in_d, data_in_q;
  logic                  write_d, write_q;
  logic [1:0]            size_d, size_q;
  logic [ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q;

  // Completion only happens while pending, so it can never coincide with an accept.
  always_comb begin
    pending_d    = pending_q;
    data_in_d    = data_in_q;
    write_d      = write_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_ready_d = complete_i;
    if (complete_i) begin
      pending_d = 1'b0;
      data_in_d = rsp_data_i;
    end else if (exec_i && !pending_q) begin
      pending_d = 1'b1;
      write_d   = write_i;
      size_d    = size_i;
      addr_d    = addr_i;
      wdata_d   = data_out_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q    <= 1'b0;
      data_ready_q <= 1'b0;
      data_in_q    <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      pending_q    <= pending_d;
      data_ready_q <= data_ready_d;
      data_in_q    <= data_in_d;
      write_q      <= write_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign ready_o      = ~pending_q;
  assign data_ready_o = data_ready_q;
  assign data_in_o    = data_in_q;
  assign pending_o    = pending_q;
  assign req_write_o  = write_q;
  assign req_size_o   = size_q;
  assign req_addr_o   = addr_q;
  assign req_data_o   = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the system memory/peripheral bus, with a per-transaction
// timeout that completes hung accesses with ERR_DATA and a bus error pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           TIMEOUT    = DEFAULT_TIMEOUT,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(DEFAULT_ERR_DATA)
) (
  input  logic                  I_clk,
  input  logic                  I_reset,
  input  logic                  M0_exec,
  input  logic                  M0_write,
  input  logic [1:0]            M0_size,
  input  logic [ADDR_WIDTH-1:0] M0_addr,
  input  logic [DATA_WIDTH-1:0] M0_data_out,
  output logic                  M0_ready,
  output logic [DATA_WIDTH-1:0] M0_data_in,
  output logic                  M0_data_ready,
  input  logic                  M1_exec,
  input  logic                  M1_write,
  input  logic [1:0]            M1_size,
  input  logic [ADDR_WIDTH-1:0] M1_addr,
  input  logic [DATA_WIDTH-1:0] M1_data_out,
  output logic                  M1_ready,
  output logic [DATA_WIDTH-1:0] M1_data_in,
  output logic                  M1_data_ready,
  output logic                  S_exec,
  output logic                  S_write,
  output logic [1:0]            S_size,
  output logic [ADDR_WIDTH-1:0] S_addr,
  output logic [DATA_WIDTH-1:0] S_data_out,
  input  logic                  S_ready,
  input  logic [DATA_WIDTH-1:0] S_data_in,
  input  logic                  S_data_ready,
  output logic                  O_bus_error,
  output logic                  O_grant
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_e state_d, state_q;
  logic       grant_d, grant_q;
  logic       last_grant_d, last_grant_q;
  logic [TimerW-1:0] timer_d, timer_q;
  logic       s_exec_d, s_exec_q;
  logic       s_write_d, s_write_q;
  logic [1:0] s_size_d, s_size_q;
  logic [ADDR_WIDTH-1:0] s_addr_d, s_addr_q;
  logic [DATA_WIDTH-1:0] s_data_d, s_data_q;
  logic       bus_error_d, bus_error_q;

  logic [1:0]                 pending;
  logic [1:0]                 req_write;
  logic [1:0][1:0]            req_size;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_data;
  logic                       winner;
  logic                       complete;
  logic                       timed_out;
  logic [1:0]                 complete_vec;
  logic [DATA_WIDTH-1:0]      rsp_data;

  // On a tie the master that did not win last time goes first.
  assign winner = (&pending) ? ~last_grant_q : pending[MASTER_DMA];

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    s_exec_d     = 1'b0;
    s_write_d    = s_write_q;
    s_size_d     = s_size_q;
    s_addr_d     = s_addr_q;
    s_data_d     = s_data_q;
    bus_error_d  = 1'b0;
    complete     = 1'b0;
    timed_out    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if ((|pending) && S_ready) begin
          grant_d   = winner;
          s_write_d = req_write[winner];
          s_size_d  = req_size[winner];
          s_addr_d  = req_addr[winner];
          s_data_d  = req_data[winner];
          s_exec_d  = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (S_data_ready) begin
          complete     = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else if ((TIMEOUT != 0) && (timer_q == TimerW'(TIMEOUT - 1))) begin
          complete     = 1'b1;
          timed_out    = 1'b1;
          bus_error_d  = 1'b1;
          last_grant_d = grant_q;
          state_d      = StIdle;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
      s_exec_q     <= 1'b0;
      s_write_q    <= 1'b0;
      s_size_q     <= '0;
      s_addr_q     <= '0;
      s_data_q     <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      s_exec_q     <= s_exec_d;
      s_write_q    <= s_write_d;
      s_size_q     <= s_size_d;
      s_addr_q     <= s_addr_d;
      s_data_q     <= s_data_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign complete_vec[MASTER_CORE] = complete && (grant_q == 1'b0);
  assign complete_vec[MASTER_DMA]  = complete && (grant_q == 1'b1);
  assign rsp_data = timed_out ? ERR_DATA : S_data_in;

  mem_arbiter_req #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_req_core (
    .clk_i       (I_clk),
    .rst_i       (I_reset),
    .exec_i      (M0_exec),
    .write_i     (M0_write),
    .size_i      (M0_size),
    .addr_i      (M0_addr),
    .data_out_i  (M0_data_out),
    .complete_i  (complete_vec[MASTER_CORE]),
    .rsp_data_i  (rsp_data),
    .ready_o     (M0_ready),
    .data_ready_o(M0_data_ready),
    .data_in_o   (M0_data_in),
    .pending_o   (pending[MASTER_CORE]),
    .req_write_o (req_write[MASTER_CORE]),
    .req_size_o  (req_size[MASTER_CORE]),
    .req_addr_o  (req_addr[MASTER_CORE]),
    .req_data_o  (req_data[MASTER_CORE])
  );

  mem_arbiter_req #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_req_dma (
    .clk_i       (I_clk),
    .rst_i       (I_reset),
    .exec_i      (M1_exec),
    .write_i     (M1_write),
    .size_i      (M1_size),
    .addr_i      (M1_addr),
    .data_out_i  (M1_data_out),
    .complete_i  (complete_vec[MASTER_DMA]),
    .rsp_data_i  (rsp_data),
    .ready_o     (M1_ready),
    .data_ready_o(M1_data_ready),
    .data_in_o   (M1_data_in),
    .pending_o   (pending[MASTER_DMA]),
    .req_write_o (req_write[MASTER_DMA]),
    .req_size_o  (req_size[MASTER_DMA]),
    .req_addr_o  (req_addr[MASTER_DMA]),
    .req_data_o  (req_data[MASTER_DMA])
  );

  assign S_exec      = s_exec_q;
  assign S_write     = s_write_q;
  assign S_size      = s_size_q;
  assign S_addr      = s_addr_q;
  assign S_data_out  = s_data_q;
  assign O_bus_error = bus_error_q;
  assign O_grant     = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple decoder model answering 3 cycles after S_exec.
module tb_mem_arbiter;

  logic        I_clk, I_reset;
  logic        M0_exec, M0_write, M0_ready, M0_data_ready;
  logic [1:0]  M0_size;
  logic [15:0] M0_addr, M0_data_out, M0_data_in;
  logic        M1_exec, M1_write, M1_ready, M1_data_ready;
  logic [1:0]  M1_size;
  logic [15:0] M1_addr, M1_data_out, M1_data_in;
  logic        S_exec, S_write, S_ready, S_data_ready, O_bus_error, O_grant;
  logic [1:0]  S_size;
  logic [15:0] S_addr, S_data_out, S_data_in;

  int tests = 0;
  int failed = 0;

  // Decoder model controls and bus monitor state
  logic        dec_on = 1'b1;
  logic [15:0] dec_resp = 16'h0000;
  int          exec_cnt = 0;
  int          done0_cnt = 0;
  int          cyc = 0;
  logic        grant_log[$];
  int          exec_cyc[$];

  mem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .TIMEOUT   (8),
    .ERR_DATA  (16'hFFFF)
  ) dut (
    .I_clk        (I_clk),
    .I_reset      (I_reset),
    .M0_exec      (M0_exec),
    .M0_write     (M0_write),
    .M0_size      (M0_size),
    .M0_addr      (M0_addr),
    .M0_data_out  (M0_data_out),
    .M0_ready     (M0_ready),
    .M0_data_in   (M0_data_in),
    .M0_data_ready(M0_data_ready),
    .M1_exec      (M1_exec),
    .M1_write     (M1_write),
    .M1_size      (M1_size),
    .M1_addr      (M1_addr),
    .M1_data_out  (M1_data_out),
    .M1_ready     (M1_ready),
    .M1_data_in   (M1_data_in),
    .M1_data_ready(M1_data_ready),
    .S_exec       (S_exec),
    .S_write      (S_write),
    .S_size       (S_size),
    .S_addr       (S_addr),
    .S_data_out   (S_data_out),
    .S_ready      (S_ready),
    .S_data_in    (S_data_in),
    .S_data_ready (S_data_ready),
    .O_bus_error  (O_bus_error),
    .O_grant      (O_grant)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  // Decoder: S_data_ready pulse is sampled by the DUT 3 edges after the S_exec edge.
  initial begin
    S_data_ready = 1'b0;
    S_data_in    = 16'h0000;
    forever begin
      @(negedge I_clk);
      if (S_exec && dec_on) begin
        repeat (2) @(negedge I_clk);
        S_data_ready = 1'b1;
        S_data_in    = dec_resp;
        @(negedge I_clk);
        S_data_ready = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge I_clk);
      cyc++;
      if (S_exec) begin
        exec_cnt++;
        grant_log.push_back(O_grant);
        exec_cyc.push_back(cyc);
      end
      if (M0_data_ready) done0_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic test_reset();
    I_reset = 1'b1;
    repeat (3) @(negedge I_clk);
    tests++; if ({M0_ready, M1_ready} !== 2'b11) begin failed++;
      $display("FAIL reset_ready: got %b required 11", {M0_ready, M1_ready}); end
    tests++; if ({M0_data_ready, M1_data_ready, S_exec, O_bus_error, O_grant} !== 5'b0) begin
      failed++; $display("FAIL reset_pulses: got %b required 00000",
                         {M0_data_ready, M1_data_ready, S_exec, O_bus_error, O_grant}); end
    tests++; if ({M0_data_in, M1_data_in} !== 32'h0) begin failed++;
      $display("FAIL reset_data_in: got %h required 0", {M0_data_in, M1_data_in}); end
    tests++; if ({S_write, S_size, S_addr, S_data_out} !== 35'h0) begin failed++;
      $display("FAIL reset_s_fields: got %h required 0", {S_write, S_size, S_addr, S_data_out});
    end
    I_reset = 1'b0;
  endtask

  task automatic test_simultaneous();
    int m0_left = 4;
    int m1_left = 4;
    grant_log.delete();
    exec_cyc.delete();
    dec_resp = 16'h1111;
    M0_write = 1'b0; M0_size = 2'b01; M0_addr = 16'h0100; M0_data_out = 16'h0;
    M1_write = 1'b0; M1_size = 2'b01; M1_addr = 16'h0200; M1_data_out = 16'h0;
    for (int c = 0; c < 60; c++) begin
      if (M0_ready && m0_left > 0) begin M0_exec = 1'b1; m0_left--; end
      else M0_exec = 1'b0;
      if (M1_ready && m1_left > 0) begin M1_exec = 1'b1; m1_left--; end
      else M1_exec = 1'b0;
      @(negedge I_clk);
    end
    M0_exec = 1'b0;
    M1_exec = 1'b0;
    tests++; if (grant_log.size() != 8) begin failed++;
      $display("FAIL alt_count: got %0d grants required 8", grant_log.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (i >= grant_log.size() || grant_log[i] !== 1'(i % 2)) begin failed++;
        $display("FAIL alt_grant[%0d]: got %b required %0d", i,
                 (i < grant_log.size()) ? grant_log[i] : 1'bx, i % 2); end
    end
    tests++; if (exec_cyc.size() < 2 || exec_cyc[1] - exec_cyc[0] != 4) begin failed++;
      $display("FAIL alt_gap: got %0d cycles required 4",
               (exec_cyc.size() < 2) ? -1 : exec_cyc[1] - exec_cyc[0]); end
  endtask

  task automatic test_single_read();
    dec_resp = 16'hBEEF;
    M0_exec = 1'b1; M0_write = 1'b0; M0_size = 2'b01; M0_addr = 16'h0010;
    @(negedge I_clk);
    M0_exec = 1'b0;
    tests++; if (M0_ready !== 1'b0) begin failed++;
      $display("FAIL rd_busy: got M0_ready=%b required 0", M0_ready); end
    @(negedge I_clk);
    tests++; if ({S_exec, S_write, O_grant, S_addr} !== {3'b100, 16'h0010}) begin failed++;
      $display("FAIL rd_issue: got exec/wr/grant/addr=%b%b%b/%h required 100/0010",
               S_exec, S_write, O_grant, S_addr); end
    @(negedge I_clk);
    tests++; if (S_exec !== 1'b0) begin failed++;
      $display("FAIL rd_exec_width: got S_exec=%b required 0", S_exec); end
    @(negedge I_clk);
    tests++; if (M0_data_ready !== 1'b0) begin failed++;
      $display("FAIL rd_early: got M0_data_ready=%b required 0", M0_data_ready); end
    @(negedge I_clk);
    tests++; if ({M0_data_ready, M0_ready, M0_data_in} !== {2'b11, 16'hBEEF}) begin failed++;
      $display("FAIL rd_done: got dr/ready/data=%b/%b/%h required 1/1/beef",
               M0_data_ready, M0_ready, M0_data_in); end
    tests++; if ({M1_ready, M1_data_ready} !== 2'b10) begin failed++;
      $display("FAIL rd_m1_quiet: got ready/dr=%b/%b required 1/0", M1_ready, M1_data_ready); end
    @(negedge I_clk);
    tests++; if (M0_data_ready !== 1'b0) begin failed++;
      $display("FAIL rd_pulse: got M0_data_ready=%b required 0", M0_data_ready); end
    repeat (2) @(negedge I_clk);
  endtask

  task automatic test_write_m1();
    dec_resp = 16'h0BAD;
    M1_exec = 1'b1; M1_write = 1'b1; M1_size = 2'b10; M1_addr = 16'h8000; M1_data_out = 16'h1234;
    @(negedge I_clk);
    M1_exec = 1'b0;
    @(negedge I_clk);
    tests++; if ({S_exec, S_write, O_grant, S_size} !== 5'b11110) begin failed++;
      $display("FAIL wr_issue: got exec/wr/grant/size=%b%b%b/%b required 111/10",
               S_exec, S_write, O_grant, S_size); end
    tests++; if ({S_addr, S_data_out} !== 32'h8000_1234) begin failed++;
      $display("FAIL wr_fields: got addr/data=%h/%h required 8000/1234", S_addr, S_data_out); end
    repeat (3) @(negedge I_clk);
    tests++; if ({M1_data_ready, M1_ready, O_bus_error, M0_data_ready} !== 4'b1100) begin
      failed++; $display("FAIL wr_done: got dr/ready/err/m0dr=%b%b%b%b required 1100",
                         M1_data_ready, M1_ready, O_bus_error, M0_data_ready); end
    tests++; if (M1_data_in !== 16'h0BAD) begin failed++;
      $display("FAIL wr_data_in: got %h required 0bad", M1_data_in); end
    repeat (2) @(negedge I_clk);
  endtask

  task automatic test_timeout();
    dec_on = 1'b0;
    M0_exec = 1'b1; M0_write = 1'b0; M0_addr = 16'h0040;
    @(negedge I_clk);
    M0_exec = 1'b0;
    M1_exec = 1'b1; M1_write = 1'b0; M1_addr = 16'h0200;
    @(negedge I_clk);
    M1_exec = 1'b0;
    tests++; if ({S_exec, O_grant} !== 2'b10) begin failed++;
      $display("FAIL to_issue: got exec/grant=%b%b required 10", S_exec, O_grant); end
    repeat (8) @(negedge I_clk);
    tests++; if ({M0_data_ready, O_bus_error} !== 2'b00) begin failed++;
      $display("FAIL to_early: got dr/err=%b%b required 00", M0_data_ready, O_bus_error); end
    @(negedge I_clk);
    tests++; if ({M0_data_ready, O_bus_error, M0_data_in} !== {2'b11, 16'hFFFF}) begin failed++;
      $display("FAIL to_done: got dr/err/data=%b%b/%h required 11/ffff",
               M0_data_ready, O_bus_error, M0_data_in); end
    dec_on = 1'b1;
    dec_resp = 16'h7777;
    @(negedge I_clk);
    tests++; if ({O_bus_error, S_exec, O_grant, S_addr} !== {3'b011, 16'h0200}) begin failed++;
      $display("FAIL to_next: got err/exec/grant/addr=%b%b%b/%h required 011/0200",
               O_bus_error, S_exec, O_grant, S_addr); end
    repeat (3) @(negedge I_clk);
    tests++; if ({M1_data_ready, O_bus_error, M1_data_in} !== {2'b10, 16'h7777}) begin failed++;
      $display("FAIL to_next_done: got dr/err/data=%b%b/%h required 10/7777",
               M1_data_ready, O_bus_error, M1_data_in); end
    repeat (2) @(negedge I_clk);
  endtask

  task automatic test_reset_wait();
    dec_on = 1'b0;
    M0_exec = 1'b1; M0_write = 1'b0; M0_addr = 16'h0020;
    @(negedge I_clk);
    M0_exec = 1'b0;
    repeat (3) @(negedge I_clk);
    I_reset = 1'b1;
    @(negedge I_clk);
    I_reset = 1'b0;
    tests++; if ({M0_ready, M0_data_ready, S_exec, O_grant, O_bus_error} !== 5'b10000) begin
      failed++; $display("FAIL rw_reset: got %b required 10000",
                         {M0_ready, M0_data_ready, S_exec, O_grant, O_bus_error}); end
    tests++; if (S_addr !== 16'h0000) begin failed++;
      $display("FAIL rw_addr: got %h required 0000", S_addr); end
    S_data_ready = 1'b1;
    S_data_in = 16'hDEAD;
    @(negedge I_clk);
    S_data_ready = 1'b0;
    tests++; if ({M0_data_ready, M1_data_ready, M0_data_in} !== 18'h0) begin failed++;
      $display("FAIL rw_late: got dr0/dr1/data=%b%b/%h required 00/0000",
               M0_data_ready, M1_data_ready, M0_data_in); end
    dec_on = 1'b1;
    dec_resp = 16'h4242;
    M1_exec = 1'b1; M1_write = 1'b0; M1_addr = 16'h0300;
    @(negedge I_clk);
    M1_exec = 1'b0;
    @(negedge I_clk);
    tests++; if ({S_exec, O_grant, S_addr} !== {2'b11, 16'h0300}) begin failed++;
      $display("FAIL rw_fresh_issue: got exec/grant/addr=%b%b/%h required 11/0300",
               S_exec, O_grant, S_addr); end
    repeat (3) @(negedge I_clk);
    tests++; if ({M1_data_ready, M1_data_in} !== {1'b1, 16'h4242}) begin failed++;
      $display("FAIL rw_fresh_done: got dr/data=%b/%h required 1/4242", M1_data_ready, M1_data_in);
    end
    repeat (2) @(negedge I_clk);
  endtask

  task automatic test_exec_busy();
    dec_resp = 16'h5555;
    exec_cnt = 0;
    done0_cnt = 0;
    M0_exec = 1'b1; M0_write = 1'b0; M0_addr = 16'h0030;
    @(negedge I_clk);
    M0_exec = 1'b0;
    repeat (2) @(negedge I_clk);
    M0_exec = 1'b1;
    M0_addr = 16'h0031;
    @(negedge I_clk);
    M0_exec = 1'b0;
    tests++; if (M0_ready !== 1'b0) begin failed++;
      $display("FAIL busy_ready: got %b required 0", M0_ready); end
    repeat (8) @(negedge I_clk);
    tests++; if (exec_cnt != 1) begin failed++;
      $display("FAIL busy_exec_cnt: got %0d required 1", exec_cnt); end
    tests++; if (done0_cnt != 1) begin failed++;
      $display("FAIL busy_done_cnt: got %0d required 1", done0_cnt); end
    tests++; if ({M0_ready, M0_data_in} !== {1'b1, 16'h5555}) begin failed++;
      $display("FAIL busy_final: got ready/data=%b/%h required 1/5555", M0_ready, M0_data_in); end
  endtask

  initial begin
    I_reset = 1'b1; S_ready = 1'b1;
    M0_exec = 1'b0; M0_write = 1'b0; M0_size = 2'b00; M0_addr = 16'h0; M0_data_out = 16'h0;
    M1_exec = 1'b0; M1_write = 1'b0; M1_size = 2'b00; M1_addr = 16'h0; M1_data_out = 16'h0;
    test_reset();
    test_simultaneous();
    test_single_read();
    test_write_m1();
    test_timeout();
    test_reset_wait();
    test_exec_busy();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single system memory/peripheral bus (the address decoder driving RAM, bootrom and UART registers) between two requesters: master 0 = core, master 1 = UART loader/DMA.
- Each master sees the same exec/ready/data_ready handshake the core already uses.
- Two-master round-robin arbitration, request latching, response routing, and a per-transaction timeout that completes hung accesses with an error pulse.

Parameters:
ADDR_WIDTH, 16, width of Mn_addr / S_addr
DATA_WIDTH, 16, width of all data buses
TIMEOUT, 255, cycles in WAIT before forced completion; 0 disables the timeout
ERR_DATA, 16'hFFFF, read data returned to a master on timeout

Ports:
I_clk  in  1  system clock
I_reset  in  1  synchronous, active-high reset
Mn_exec (n=0,1)  in  1  request strobe, sampled only while Mn_ready=1
Mn_write  in  1  1=write, 0=read; sampled with Mn_exec
Mn_size  in  2  access size, passed through unchanged
Mn_addr  in  ADDR_WIDTH  access address
Mn_data_out  in  DATA_WIDTH  write data from master
Mn_ready  out  1  master may issue; low from accept until completion
Mn_data_in  out  DATA_WIDTH  response data to master
Mn_data_ready  out  1  one-cycle completion pulse
S_exec  out  1  one-cycle request pulse to the bus decoder
S_write  out  1  latched write flag of granted request
S_size  out  2  latched size
S_addr  out  ADDR_WIDTH  latched address
S_data_out  out  DATA_WIDTH  latched write data
S_ready  in  1  decoder idle
S_data_in  in  DATA_WIDTH  decoder response data
S_data_ready  in  1  decoder completion pulse (reads and writes)
O_bus_error  out  1  one-cycle pulse on timeout completion
O_grant  out  1  index of the master owning the bus (valid in ISSUE/WAIT)

Behaviour:
- Reset (sync):
  - Mn_ready=1, Mn_data_ready=0, Mn_data_in=0.
  - S_exec=0; S_write/S_size/S_addr/S_data_out=0.
  - O_bus_error=0, O_grant=0.
  - pending[1:0]=0, last_grant=1 (so M0 wins the first tie), timer=0, state=IDLE.
  - Reset mid-transaction drops everything; no completion pulse is generated.
- Accept:
  - At an edge with Mn_exec=1 and Mn_ready=1: latch write/size/addr/data_out into the per-master request register, set pending[n], and set Mn_ready=0.
  - Mn_exec is ignored while Mn_ready=0.
- States IDLE, ISSUE, WAIT.
- IDLE:
  - If any pending and S_ready=1: pick a winner, load the S_* fields from its request register, set O_grant, S_exec<=1, go to ISSUE.
  - Arbitration uses registered pending only, so a request accepted this edge is eligible next cycle.
  - Winner: the only pending master; if both are pending, the master != last_grant.
- ISSUE: S_exec<=0, timer<=0, go to WAIT. S_exec is exactly one cycle wide.
- WAIT:
  - On S_data_ready=1: Mg_data_in<=S_data_in, Mg_data_ready<=1 (one cycle), Mg_ready<=1, clear pending[g], last_grant<=g, go to IDLE.
  - Otherwise timer increments.
  - If TIMEOUT!=0 and timer==TIMEOUT-1 with no S_data_ready: complete as above but with Mg_data_in<=ERR_DATA and O_bus_error<=1.
  - S_data_ready on the same cycle as the timeout wins (normal completion, no error).
- Latency: accept edge t0 → S_exec high t1..t2 → completion edge = S_data_ready edge. Arbiter overhead is 2 cycles plus decoder latency.
- Back-to-back:
  - A completed master may re-issue the cycle after its Mn_ready rises.
  - The other master's pending request is granted from IDLE first.
  - Under continuous load both masters strictly alternate.
- S_data_ready outside WAIT is ignored. S_* fields hold their value until the next grant.
- S_data_out is driven for reads too (don't-care for the decoder).

Decomposition:
- Shared include (alongside the memory map header): state encodings, MASTER_CORE=0 / MASTER_DMA=1, default TIMEOUT and ERR_DATA.
- One natural sub-module, mem_arbiter_req: per-master accept/pending/request-register plus Mn_ready/Mn_data_ready/Mn_data_in generation. It is instantiated twice.
- The top holds the FSM, the round-robin pick, the timer and the S_* mux.

Test Plan:
- Single M0 read: M0 addr=0x0010; decoder returns 0xBEEF 3 cycles after S_exec → S_exec one cycle with S_addr=0x0010, M0_data_in=0xBEEF, M0_data_ready one pulse, M0_ready back to 1 in the same cycle, M1 untouched.
- Simultaneous: M0 and M1 exec on the same edge after reset → M0 granted first, M1 issued in the IDLE cycle after M0 completes; 4 consecutive pairs alternate 0,1,0,1.
- M1 write: addr=0x8000, data=0x1234 → S_write=1, S_data_out=0x1234, M1_data_ready pulse on S_data_ready, no error.
- Timeout: TIMEOUT=8, decoder never responds → completion exactly 8 cycles after entering WAIT, M0_data_in=0xFFFF, O_bus_error one pulse, next pending request still served.
- Reset during WAIT: I_reset high for one cycle → all outputs at reset values next cycle; a late S_data_ready is ignored; a fresh M1 request completes normally.
- Exec while busy: pulse M0_exec while M0_ready=0 → no second transaction issued, pending count unchanged.
